// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle processor core: sequencer state
// encoding, condition-flag bit positions and the default reset PC.
// jump_unit decodes the flag vector with the same bit indices.
package cpu_pkg;

   // Instruction-cycle states, 2-bit encoding.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_HALT  = 2'd3
   } seq_state_t;

   // Condition-flag layout: {carry, sign, zero}.
   localparam int FLAG_W = 3;
   localparam int FLAG_C = 2;
   localparam int FLAG_S = 1;
   localparam int FLAG_Z = 0;

   // PC loaded when rst is asserted, unless the instance overrides it.
   localparam logic [31:0] DEFAULT_RESET_PC = 32'd0;

   // An instruction commits on an EXEC edge that is not stalled.
   function automatic logic is_commit(input seq_state_t st, input logic stall_i);
      return (st == ST_EXEC) && !stall_i;
   endfunction

endpackage

// File: rtl/flag_reg.sv
// Condition-flag register: 3 bits, synchronous active-high reset to zero,
// loads d on any rising edge where we is high.
module flag_reg
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [FLAG_W-1:0] d,
   output logic [FLAG_W-1:0] q
);

   // Flags hold until an enabled write; reset clears them.
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (we) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter / flag sequencer. Owns the architectural PC and the
// condition flags, feeds both to jump_unit, and commits jump_unit's
// next_address once per instruction through a FETCH/EXEC cycle.
//
// Control semantics: start is a level sampled only in IDLE. stall is a
// level that freezes the current state and all architectural state for
// as long as it is high. next_address, alu_flags, flag_we and halt_req
// are sampled only on the EXEC edge where stall is low (the commit edge);
// their values at any other time are ignored.
module pc_sequencer
   import cpu_pkg::*;
#(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stall,
   input  logic              halt_req,
   input  logic [WIDTH-1:0]  next_address,
   input  logic [FLAG_W-1:0] alu_flags,
   input  logic              flag_we,
   output logic [WIDTH-1:0]  pc,
   output logic [FLAG_W-1:0] flags,
   output logic              fetch_en,
   output logic              exec_en,
   output logic              halted,
   output logic [31:0]       retired,
   output logic [1:0]        state_dbg
);

   seq_state_t state;
   seq_state_t state_nxt;
   logic       commit;

   assign commit    = is_commit(state, stall);
   assign state_dbg = state;

   // Next-state decode; stall holds FETCH and EXEC, HALT is left only by rst.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (!stall) begin
               state_nxt = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (!stall) begin
               state_nxt = halt_req ? ST_HALT : ST_FETCH;
            end
         end
         ST_HALT: begin
            state_nxt = ST_HALT;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register, PC/retired commit and Moore enables registered from
   // the next state so they line up exactly with the state they decode.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         pc       <= RESET_PC;
         retired  <= 32'd0;
         fetch_en <= 1'b0;
         exec_en  <= 1'b0;
         halted   <= 1'b0;
      end else begin
         state    <= state_nxt;
         fetch_en <= (state_nxt == ST_FETCH);
         exec_en  <= (state_nxt == ST_EXEC);
         halted   <= (state_nxt == ST_HALT);
         if (commit) begin
            // next_address already carries sequential or branch target;
            // it is taken verbatim, no increment or alignment here.
            pc      <= next_address;
            retired <= retired + 32'd1;
         end
      end
   end

   // Flags written only on the commit edge, so a branch sees the flags of
   // earlier instructions and this instruction's update shows up next time.
   flag_reg u_flag_reg (
      .clk (clk),
      .rst (rst),
      .we  (commit && flag_we),
      .d   (alu_flags),
      .q   (flags)
   );

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter and flag-register sequencer for the multicycle processor. It owns the architectural PC and the 3-bit condition-flag register and presents both to `jump_unit` as `PCin` and `flags`. It then takes `jump_unit`'s `next_address` back and commits it at the end of each instruction, so it sits at the opposite end of the PC/flags ↔ next-address path. A FETCH/EXEC state machine drives the instruction cycle, with stall, halt and a retired-instruction counter.

## Interface
- `WIDTH`, default 32: PC and address width.
- `RESET_PC`, default 32'd0: PC value loaded on reset.
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: leaves IDLE; ignored in every other state.
- `stall`, input, 1: holds the current state (memory wait).
- `halt_req`, input, 1: the executing instruction is HLT.
- `next_address`, input, `WIDTH`: from `jump_unit`; valid in EXEC.
- `alu_flags`, input, 3: bit 2 = carry, bit 1 = sign, bit 0 = zero.
- `flag_we`, input, 1: the executing instruction updates flags.
- `pc`, output, `WIDTH`: current PC; drives `jump_unit.PCin` and the instruction-memory address.
- `flags`, output, 3: registered flags; drives `jump_unit.flags`.
- `fetch_en`, output, 1: high in FETCH.
- `exec_en`, output, 1: high in EXEC.
- `halted`, output, 1: high in HALT.
- `retired`, output, 32: count of committed instructions.

## Operation
States: IDLE, FETCH, EXEC, HALT, encoded in 2 bits.
- **IDLE:** `start`=1 → FETCH; otherwise stay.
- **FETCH:** `fetch_en`=1. If `stall`=1, stay; otherwise go to EXEC.
- **EXEC:** `exec_en`=1. If `stall`=1, stay and change nothing. Otherwise commit in one edge:
  - `pc` ← `next_address`;
  - `flags` ← `alu_flags` if `flag_we`, else unchanged;
  - `retired` ← `retired`+1;
  - next state is HALT if `halt_req`, else FETCH.
- **HALT:** `halted`=1. Only `rst` exits.
- `pc` does not increment in this block. Sequential and branch targets both arrive via `next_address`, which is committed verbatim with no alignment or masking.
- Conditional branches are evaluated against the flags committed by earlier instructions. A flag update by the current instruction becomes visible to the next instruction.
- `retired` wraps from 2^32−1 to 0.
- `fetch_en`, `exec_en` and `halted` are Moore outputs decoded from the state.

## Timing
- **Reset values:** state=IDLE, `pc`=`RESET_PC`, `flags`=3'b000, `retired`=0, `fetch_en`=`exec_en`=`halted`=0.
- **Latency:** with no stall, an instruction takes 2 cycles (FETCH, then EXEC). `pc` changes on the edge that ends EXEC.
- **Priority:**
  - `rst` beats everything, including a reset asserted mid-EXEC, which discards the commit.
  - `stall` beats `halt_req` and `flag_we`.
  - `halt_req` with `flag_we` commits both the flags and the PC, then enters HALT.
- `next_address`, `alu_flags`, `flag_we` and `halt_req` are sampled only on an EXEC edge with `stall`=0. Their values in all other states are don't-care.
- `start` held high continuously has no effect after IDLE.

## Structure
- **Shared package `cpu_pkg`:** state enum; flag bit indices `FLAG_C`=2, `FLAG_S`=1, `FLAG_Z`=0; default `RESET_PC`. `jump_unit` decodes flags with the same indices.
- **Sub-module `flag_reg`:** a 3-bit register with synchronous reset and write enable. Everything else is one module.

## Test plan
- **Reset then idle:** assert `rst` 2 cycles → `pc`=0, `flags`=0, `retired`=0, all enables 0. With `start`=0 for 5 cycles, the state stays IDLE.
- **Single commit:** pulse `start`; in EXEC drive `next_address`=35, `flag_we`=0 → `fetch_en` is high 1 cycle, then `exec_en` 1 cycle; then `pc`=35 and `retired`=1.
- **Stall:** assert `stall` for 3 cycles in FETCH and 2 cycles in EXEC (with `next_address`=45) → `pc` is unchanged until the first unstalled EXEC edge, then becomes 45. `retired` increments exactly once.
- **Flags:** EXEC with `flag_we`=1, `alu_flags`=3'b001 → `flags`=001. Next EXEC with `flag_we`=0, `alu_flags`=3'b110 → `flags` stays 001.
- **Halt:** EXEC with `halt_req`=1, `next_address`=7 → `pc`=7 and `halted`=1. `start` pulses afterwards change nothing. `rst` returns to IDLE with `pc`=0.
- **Reset mid-EXEC:** `rst` on an EXEC edge with `next_address`=99, `flag_we`=1 → `pc`=`RESET_PC`, `flags`=0, `retired` is not incremented, state=IDLE.
